// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row drive, column synchronizer, frame-level
// debounce, and single-cycle key code pulses with a held indication.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_out,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned SW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);

  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_HELD = 1'b1
  } key_state_e;

  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    row_q;
  logic [3:0]    row_out_q;
  logic [3:0]    cand_q;
  logic [3:0]    prev_q;
  logic [SW-1:0] stable_q;
  logic [3:0]    rep_q;
  logic [3:0]    key_q;
  logic          valid_q;
  key_state_e    state_q;

  logic          last_dwell;
  logic          frame_end;
  logic [3:0]    row_base;
  logic [3:0]    row_code;
  logic [3:0]    cand_d;
  logic [SW-1:0] stable_d;

  assign last_dwell = (dwell_q == DWELL_LAST);
  assign frame_end  = last_dwell && (row_q == 2'd3);

  // Two-flop synchronizer for the asynchronous, pulled-up columns.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= col_in;
      sync2_q <= sync1_q;
    end
  end

  // Row scan: hold each row for SCAN_DIV cycles, rotating the active-low drive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dwell_q   <= '0;
      row_q     <= '0;
      row_out_q <= 4'b1110;
    end else if (last_dwell) begin
      dwell_q   <= '0;
      row_q     <= row_q + 2'd1;
      row_out_q <= {row_out_q[2:0], row_out_q[3]};
    end else begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  // Lowest pressed code in the current row, and the frame candidate including it.
  always_comb begin
    row_base = ({2'b00, row_q} * 4'd3) + 4'd1;
    row_code = '0;
    if (!sync2_q[0]) begin
      row_code = row_base;
    end else if (!sync2_q[1]) begin
      row_code = row_base + 4'd1;
    end else if (!sync2_q[2]) begin
      row_code = row_base + 4'd2;
    end
    // Earlier rows carry lower codes, so a latched candidate always wins.
    cand_d = (cand_q != '0) ? cand_q : row_code;
  end

  // Run length of identical frame candidates, saturating at DEBOUNCE.
  always_comb begin
    stable_d = SW'(1);
    if (cand_d == prev_q) begin
      stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1);
    end
  end

  // Frame bookkeeping and press/release acceptance with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cand_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      rep_q    <= '0;
      key_q    <= '0;
      valid_q  <= 1'b0;
      state_q  <= KS_IDLE;
    end else begin
      key_q   <= '0;
      valid_q <= 1'b0;
      if (frame_end) begin
        cand_q   <= '0;
        prev_q   <= cand_d;
        stable_q <= stable_d;
        if (stable_d == STABLE_MAX) begin
          if ((cand_d != '0) && (cand_d != rep_q)) begin
            key_q   <= cand_d;
            valid_q <= 1'b1;
            rep_q   <= cand_d;
            state_q <= KS_HELD;
          end else if ((cand_d == '0) && (state_q == KS_HELD)) begin
            rep_q   <= '0;
            state_q <= KS_IDLE;
          end
        end
      end else if (last_dwell) begin
        cand_q <= cand_d;
      end
    end
  end

  assign row_out   = row_out_q;
  assign key_out   = key_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == KS_HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: frame-level keypad model plus per-cycle compare.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 3;
  localparam int unsigned F        = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_out;
  logic       key_valid;
  logic       key_held;

  // Pressed keys, bit (code-1); changed only at frame boundaries.
  logic [11:0] keys = '0;

  int errors = 0;
  int checks = 0;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_out  (key_out),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its column low while its row is driven.
  always @* begin
    col_in = 3'b111;
    for (int r = 0; r < 4; r++) begin
      if (row_out[r] === 1'b0) begin
        for (int c = 0; c < 3; c++) begin
          if (keys[r*3+c]) col_in[c] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state (frame level)
  logic        rst_prev = 1'b1;
  bit          started  = 1'b0;
  int          ph;
  int          cyc;
  int          hist[$];
  int          rep;
  bit          m_held;
  int          exp_key;
  logic [11:0] frame_keys;
  logic [3:0]  exp_row;
  int          pcyc[$];
  int          pcode[$];

  // Evaluate one completed frame: last DEBOUNCE candidates identical => stable.
  function automatic void model_frame();
    int cand;
    bit stable;
    cand = 0;
    for (int i = 11; i >= 0; i--) if (frame_keys[i]) cand = i + 1;
    hist.push_back(cand);
    if (hist.size() > DEBOUNCE) void'(hist.pop_front());
    stable = (hist.size() == DEBOUNCE);
    foreach (hist[i]) if (hist[i] != cand) stable = 1'b0;
    if (stable && cand != 0 && cand != rep) begin
      exp_key = cand;
      rep     = cand;
      m_held  = 1'b1;
    end else if (stable && cand == 0 && m_held) begin
      m_held = 1'b0;
      rep    = 0;
    end
  endfunction

  // Compare process: one sample per cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_prev === 1'b0) begin
      started = 1'b1;
      ph      = 0;
      cyc     = 0;
      hist.delete();
      rep     = 0;
      m_held  = 1'b0;
      exp_key = 0;
    end else if (started) begin
      cyc++;
      ph      = (ph + 1) % F;
      exp_key = 0;
      if (ph == 0) model_frame();
    end
    if (started) begin
      if (ph == F - 1) frame_keys = keys;
      exp_row = ~(4'b0001 << (ph / SCAN_DIV));
      chk("row_out",   row_out,   exp_row);
      chk("key_out",   key_out,   exp_key);
      chk("key_valid", key_valid, (exp_key != 0));
      chk("key_held",  key_held,  m_held);
      if (key_valid === 1'b1) begin
        pcyc.push_back(cyc);
        pcode.push_back(int'(key_out));
      end
    end
    rst_prev = rst;
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    pcyc.delete();
    pcode.delete();
  endtask

  task automatic frames(input logic [11:0] m, input int n);
    keys = m;
    repeat (n * F) @(posedge clk);
    #1;
  endtask

  task automatic chk_pulse(input string name, input int idx, input int code, input int at);
    if (pcode.size() > idx) begin
      chk({name, "_code"}, pcode[idx], code);
      chk({name, "_cyc"},  pcyc[idx],  at);
    end
  endtask

  initial begin
    rst = 1'b0;

    // Reset and idle scanning
    do_reset();
    chk("rst_row_out", row_out, 4'b1110);
    chk("rst_key_out", key_out, 4'b0000);
    chk("rst_held",    key_held, 1'b0);
    frames(12'h000, 3);
    chk("idle_npulse", pcyc.size(), 0);

    // Single press (0,2)
    do_reset();
    frames(12'h004, 10);
    chk("single_npulse", pcyc.size(), 1);
    chk_pulse("single", 0, 3, 48);
    chk("single_held", key_held, 1'b1);
    frames(12'h000, 4);

    // Bounce on (0,0)
    do_reset();
    frames(12'h001, 1);
    frames(12'h000, 1);
    frames(12'h001, 4);
    chk("bounce_npulse", pcyc.size(), 1);
    chk_pulse("bounce", 0, 1, 80);

    // Multi-key (1,1)+(3,2), then keep only (3,2)
    do_reset();
    frames(12'h810, 4);
    frames(12'h800, 4);
    chk("multi_npulse", pcyc.size(), 2);
    chk_pulse("multi0", 0, 5, 48);
    chk_pulse("multi1", 1, 12, 112);
    chk("multi_held", key_held, 1'b1);

    // Release too short, then long enough
    do_reset();
    frames(12'h001, 4);
    frames(12'h000, 2);
    frames(12'h001, 4);
    chk("short_rel_npulse", pcyc.size(), 1);
    frames(12'h000, 3);
    chk("long_rel_held", key_held, 1'b0);
    frames(12'h001, 4);
    chk("repress_npulse", pcyc.size(), 2);
    chk_pulse("repress", 1, 1, 256);

    // Reset in the middle of a held press
    do_reset();
    frames(12'h004, 5);
    chk("pre_rst_held", key_held, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    chk("midrst_held",    key_held, 1'b0);
    chk("midrst_row_out", row_out,  4'b1110);
    frames(12'h004, 4);
    chk("midrst_npulse", pcyc.size(), 1);
    chk_pulse("midrst", 0, 3, 48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
